// File: rtl/sin_ns.sv
// sin_ns: interpolating first/second-order error-feedback 1-bit noise shaper for the DAC path.
// Build option: define SIN_NS_DITHER_EN to add 1-LSB LFSR dither ahead of the quantiser.
module sin_ns #(
    parameter int WIDTH    = 16,
    parameter int OSR_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             order2,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_p,
    output logic             out_n,
    output logic             busy,
    output logic             underrun
);

    localparam int AW = WIDTH + OSR_LOG2 + 1;
    localparam int MW = WIDTH + 4;

    localparam logic [OSR_LOG2-1:0]  KLast  = {OSR_LOG2{1'b1}};
    localparam logic signed [MW-1:0] FsPos  = {4'b0000, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic signed [MW-1:0] FsNeg  = -FsPos;
    localparam logic signed [MW-1:0] SatPos = {2'b00, 1'b1, {(WIDTH + 1){1'b0}}};
    localparam logic signed [MW-1:0] SatNeg = -SatPos;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic signed [WIDTH-1:0] prev_q, prev_d;
    logic signed [WIDTH-1:0] cur_q, cur_d;
    logic signed [WIDTH-1:0] buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [OSR_LOG2-1:0]     k_q, k_d;
    logic                    underrun_q, underrun_d;
    logic signed [MW-1:0]    e1_q, e1_d;
    logic signed [MW-1:0]    e2_q, e2_d;
    logic                    out_p_q, out_p_d;
    logic                    out_n_q, out_n_d;
    logic                    order2_q, order2_d;

    logic                    handshake;
    logic signed [WIDTH:0]   delta;
    logic signed [AW-1:0]    delta_ext;
    logic signed [MW-1:0]    y_ext;
    logic signed [MW-1:0]    fb;
    logic signed [MW-1:0]    v;
    logic signed [MW-1:0]    q;
    logic signed [MW-1:0]    err;
    logic signed [MW-1:0]    err_sat;
    logic                    v_pos;
    logic                    dither;
    logic                    unused_acc_bits;

    // Accumulator value at the start of an interval: sample scaled by N.
    function automatic logic signed [AW-1:0] interval_start(input logic [WIDTH-1:0] s);
        return {s[WIDTH-1], s, {OSR_LOG2{1'b0}}};
    endfunction

    assign in_ready  = ~buf_full_q;
    assign handshake = in_valid & in_ready;

    assign delta     = $signed({cur_q[WIDTH-1], cur_q}) - $signed({prev_q[WIDTH-1], prev_q});
    assign delta_ext = AW'(delta);

    // acc >>> OSR_LOG2; the result always lies between prev and cur so it fits WIDTH bits.
    assign y               = acc_q[OSR_LOG2 +: WIDTH];
    assign unused_acc_bits = ^{acc_q[AW-1], acc_q[OSR_LOG2-1:0]};

`ifdef SIN_NS_DITHER_EN
    localparam logic [15:0] LfsrSeed = 16'hACE1;

    logic [15:0] lfsr_q, lfsr_d;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    always_comb begin
        lfsr_d = LfsrSeed;
        if (state_q == StRun && en) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither = lfsr_q[0];
`else
    assign dither = 1'b0;
`endif

    // Error feedback: second order subtracts 2*e1 - e2, first order subtracts e1.
    assign y_ext = MW'($signed(y));
    assign fb    = order2_q ? ((e1_q <<< 1) - e2_q) : e1_q;
    assign v     = y_ext - fb + MW'(dither);
    assign v_pos = ~v[MW-1];
    assign q     = v_pos ? FsPos : FsNeg;
    assign err   = q - v;

    always_comb begin
        err_sat = err;
        if (err > SatPos) begin
            err_sat = SatPos;
        end else if (err < SatNeg) begin
            err_sat = SatNeg;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        acc_d      = acc_q;
        k_d        = k_q;
        underrun_d = underrun_q;
        e1_d       = e1_q;
        e2_d       = e2_q;
        out_p_d    = out_p_q;
        out_n_d    = out_n_q;
        order2_d   = order2_q;

        unique case (state_q)
            StIdle: begin
                order2_d = order2;
                if (en && handshake) begin
                    state_d = StRun;
                    prev_d  = in_data;
                    cur_d   = in_data;
                    acc_d   = interval_start(in_data);
                    k_d     = '0;
                end
            end

            StRun: begin
                if (!en) begin
                    // Mute and flush everything so the next start is clean.
                    state_d    = StIdle;
                    prev_d     = '0;
                    cur_d      = '0;
                    buf_d      = '0;
                    buf_full_d = 1'b0;
                    acc_d      = '0;
                    k_d        = '0;
                    underrun_d = 1'b0;
                    e1_d       = '0;
                    e2_d       = '0;
                    out_p_d    = 1'b0;
                    out_n_d    = 1'b0;
                end else begin
                    if (k_q == KLast) begin
                        k_d    = '0;
                        prev_d = cur_q;
                        acc_d  = interval_start(cur_q);
                        if (buf_full_q) begin
                            cur_d      = buf_q;
                            buf_full_d = 1'b0;
                        end else if (handshake) begin
                            cur_d = in_data;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end else begin
                        k_d   = k_q + OSR_LOG2'(1);
                        acc_d = acc_q + delta_ext;
                        if (handshake) begin
                            buf_d      = in_data;
                            buf_full_d = 1'b1;
                        end
                    end

                    e1_d    = err_sat;
                    e2_d    = e1_q;
                    out_p_d = v_pos;
                    out_n_d = ~v_pos;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            prev_q     <= '0;
            cur_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            acc_q      <= '0;
            k_q        <= '0;
            underrun_q <= 1'b0;
            e1_q       <= '0;
            e2_q       <= '0;
            out_p_q    <= 1'b0;
            out_n_q    <= 1'b0;
            order2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            underrun_q <= underrun_d;
            e1_q       <= e1_d;
            e2_q       <= e2_d;
            out_p_q    <= out_p_d;
            out_n_q    <= out_n_d;
            order2_q   <= order2_d;
        end
    end

    assign out_p    = out_p_q;
    assign out_n    = out_n_q;
    assign busy     = (state_q == StRun);
    assign underrun = underrun_q;

endmodule
